// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front-end.
//   FN_*    : request function codes seen on in_func
//   OP_*    : 4-bit operation encoding understood by the external ALU
//   dec_t   : decode result {illegal, op}
//   decode(): maps a function code to dec_t; illegal codes give OP_ADD
package alu_pkg;

  localparam logic [3:0] FN_ADD   = 4'd0;
  localparam logic [3:0] FN_SUB   = 4'd1;
  localparam logic [3:0] FN_RSUB  = 4'd2;
  localparam logic [3:0] FN_AND   = 4'd3;
  localparam logic [3:0] FN_OR    = 4'd4;
  localparam logic [3:0] FN_XOR   = 4'd5;
  localparam logic [3:0] FN_PASSB = 4'd6;
  localparam logic [3:0] FN_ANDN  = 4'd7;
  localparam logic [3:0] FN_ORN   = 4'd8;
  localparam logic [3:0] FN_XNOR  = 4'd9;
  localparam logic [3:0] FN_NOTB  = 4'd10;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_RSUB  = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b1000;
  localparam logic [3:0] OP_OR    = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1100;
  localparam logic [3:0] OP_PASSB = 4'b1101;
  localparam logic [3:0] OP_ANDN  = 4'b1010;
  localparam logic [3:0] OP_ORN   = 4'b1011;
  localparam logic [3:0] OP_XNOR  = 4'b1110;
  localparam logic [3:0] OP_NOTB  = 4'b1111;

  typedef struct packed {
    logic       illegal;
    logic [3:0] op;
  } dec_t;

  // Illegal codes still produce a defined op (ADD) so the ALU never sees
  // an unassigned encoding; the result is discarded downstream.
  function automatic dec_t decode(input logic [3:0] func);
    dec_t d;
    d.illegal = 1'b0;
    d.op      = OP_ADD;
    case (func)
      FN_ADD:   d.op = OP_ADD;
      FN_SUB:   d.op = OP_SUB;
      FN_RSUB:  d.op = OP_RSUB;
      FN_AND:   d.op = OP_AND;
      FN_OR:    d.op = OP_OR;
      FN_XOR:   d.op = OP_XOR;
      FN_PASSB: d.op = OP_PASSB;
      FN_ANDN:  d.op = OP_ANDN;
      FN_ORN:   d.op = OP_ORN;
      FN_XNOR:  d.op = OP_XNOR;
      FN_NOTB:  d.op = OP_NOTB;
      default:  d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result buffer between the ALU capture stage and writeback.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail (ignored when full)
//   push_data  : W-bit payload
//   pop        : drop the head entry (ignored when empty)
//   head       : payload at the head (meaningful only when count != 0)
//   count      : number of stored entries, 0..DEPTH
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CNT_MAX);
  assign do_pop  = pop  && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the head is only looked at when count != 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback front-end for the external 32-bit combinational ALU.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : request handshake; in_func/in_a/in_b/in_tag payload
//   alu_a/alu_b/alu_op   : registered operands and op to the ALU
//   alu_result           : combinational ALU result for the current alu_* inputs
//   out_valid/out_ready  : result handshake from the FIFO head
//   out_result/out_zero/out_err/out_tag : head payload (0/1/0/0 when empty)
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_func,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = 32 + 2 + TAG_W;
  localparam logic [CW:0] OCC_LIMIT = (CW+1)'(DEPTH);

  dec_t             dec;
  logic             accept;
  logic             s1_valid;
  logic             s1_illegal;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      s1_res;
  logic [PW-1:0]    push_data;
  logic [PW-1:0]    head;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;
  logic             pop;

  logic [31:0]      head_result;
  logic             head_zero;
  logic             head_err;
  logic [TAG_W-1:0] head_tag;

  assign dec = decode(in_func);

  // Counting the stage-1 entry reserves its FIFO slot in advance, so a push
  // can never meet a full FIFO and in_ready stays purely registered.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
  assign in_ready  = occupancy < OCC_LIMIT;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      s1_tag     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_illegal <= dec.illegal;
        s1_tag     <= in_tag;
        alu_a      <= in_a;
        alu_b      <= in_b;
        alu_op     <= dec.op;
      end
    end
  end

  assign s1_res    = s1_illegal ? 32'd0 : alu_result;
  assign push_data = {s1_res, (s1_res == 32'd0), s1_illegal, s1_tag};
  assign pop       = out_valid && out_ready;

  alu_result_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign {head_result, head_zero, head_err, head_tag} = head;

  // Empty head reads as a zero result so out_zero stays consistent with it.
  assign out_valid  = (fifo_count != '0);
  assign out_result = out_valid ? head_result : 32'd0;
  assign out_zero   = out_valid ? head_zero   : 1'b1;
  assign out_err    = out_valid ? head_err    : 1'b0;
  assign out_tag    = out_valid ? head_tag    : '0;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_func;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_op;
  logic [31:0]      alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_zero;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .out_tag    (out_tag)
  );

  // Stand-in for the external ALU, keyed on its own op encoding.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0101: alu_result = alu_b - alu_a;
      4'b1000: alu_result = alu_a & alu_b;
      4'b1001: alu_result = alu_a | alu_b;
      4'b1100: alu_result = alu_a ^ alu_b;
      4'b1101: alu_result = alu_b;
      4'b1010: alu_result = alu_a & ~alu_b;
      4'b1011: alu_result = ~alu_b | alu_a;
      4'b1110: alu_result = alu_a ^ ~alu_b;
      4'b1111: alu_result = ~alu_b;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model: expected results per request, straight from the
  // function-code definitions.
  typedef struct {
    logic [31:0]      res;
    logic             zero;
    logic             err;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t        q[$];
  res_t        pend_r;
  logic        pend_v = 1'b0;
  logic [3:0]  pend_op;
  logic [31:0] pend_a;
  logic [31:0] pend_b;
  int          dut_acc = 0;

  function automatic logic [3:0] exp_op(input logic [3:0] f);
    case (f)
      4'd0:    return 4'b0000;
      4'd1:    return 4'b0110;
      4'd2:    return 4'b0101;
      4'd3:    return 4'b1000;
      4'd4:    return 4'b1001;
      4'd5:    return 4'b1100;
      4'd6:    return 4'b1101;
      4'd7:    return 4'b1010;
      4'd8:    return 4'b1011;
      4'd9:    return 4'b1110;
      4'd10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return b - a;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return b;
      4'd7:    return a & ~b;
      4'd8:    return ~b | a;
      4'd9:    return ~(a ^ b);
      4'd10:   return ~b;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check visible state at the falling edge, drive the inputs
  // for the next rising edge, then advance the model across that edge.
  task automatic cyc(input logic v, input logic [3:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [TAG_W-1:0] t, input logic ordy);
    logic exp_rdy;
    logic do_pop;
    res_t tmp;
    @(negedge clk);
    exp_rdy = (q.size() + int'(pend_v)) < DEPTH;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0].res);
      chk("out_zero", 32'(out_zero), 32'(q[0].zero));
      chk("out_err", 32'(out_err), 32'(q[0].err));
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
    end
    if (pend_v) begin
      chk("alu_op", 32'(alu_op), 32'(pend_op));
      chk("alu_a", alu_a, pend_a);
      chk("alu_b", alu_b, pend_b);
    end
    in_valid  = v;
    in_func   = f;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    if (v && in_ready) dut_acc++;
    do_pop = (q.size() != 0) && ordy;
    if (do_pop) tmp = q.pop_front();
    if (pend_v) q.push_back(pend_r);
    pend_v = v && exp_rdy;
    if (pend_v) begin
      pend_r.err  = (f > 4'd10);
      pend_r.res  = pend_r.err ? 32'd0 : ref_res(f, a, b);
      pend_r.zero = (pend_r.res == 32'd0);
      pend_r.tag  = t;
      pend_op     = exp_op(f);
      pend_a      = a;
      pend_b      = b;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, '0, 1'b1);
  endtask

  initial begin
    int acc0;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_func   = 4'd0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_tag    = '0;
    out_ready = 1'b0;
    #3;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_zero", 32'(out_zero), 32'd1);
    chk("rst out_err", 32'(out_err), 32'd0);
    chk("rst out_tag", 32'(out_tag), 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst alu_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD wrap to zero
    cyc(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 4'd3, 1'b1);
    idle(3);

    // back-to-back funcs 0..7 at full rate
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 4'(i), 32'h0F0F_0F0F, 32'h00FF_00FF, 4'(i), 1'b1);
    idle(3);

    // backpressure: exactly DEPTH accepts, then one more per freed slot
    acc0 = dut_acc;
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 4'($urandom_range(0, 10)), $urandom, $urandom, 4'(i), 1'b0);
    chk("accepts when blocked", 32'(dut_acc - acc0), 32'd4);
    cyc(1'b1, 4'd3, $urandom, $urandom, 4'd8, 1'b1);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 4'd4, $urandom, $urandom, 4'd9, 1'b0);
    chk("accepts after one pop", 32'(dut_acc - acc0), 32'd5);
    idle(8);

    // illegal function code
    cyc(1'b1, 4'd12, 32'd5, 32'd7, 4'd6, 1'b1);
    idle(3);

    // NOTB of zero, XNOR of equal operands
    cyc(1'b1, 4'd10, 32'hABCD_0123, 32'd0, 4'd1, 1'b1);
    cyc(1'b1, 4'd9, 32'h1234_5678, 32'h1234_5678, 4'd2, 1'b1);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      if ($urandom_range(0, 9) == 0) ra = 32'd0;
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra, rb,
          4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
    end
    idle(10);

    // reset with three results buffered and one in flight
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 4'd0, 32'(i), 32'(i), 4'(i), 1'b0);
    @(posedge clk);
    #1;
    chk("pre-reset in_ready", 32'(in_ready), 32'd0);
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("mid-reset out_valid", 32'(out_valid), 32'd0);
    chk("mid-reset in_ready", 32'(in_ready), 32'd1);
    q.delete();
    pend_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 4'd0, 32'd2, 32'd2, 4'd5, 1'b1);
    idle(3);
    chk("drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue and writeback front-end for the 32-bit combinational ALU. Accepts function-coded operation requests on a valid/ready handshake and decodes the function code to the ALU's 4-bit operation encoding. Drives registered operands and opcode to the ALU, captures the ALU result one cycle later, and buffers results in a small FIFO. The FIFO drains to the writeback stage on a second valid/ready handshake.

## Interface
- DEPTH, 4, result FIFO entries; power of two, ≥2
- TAG_W, 4, width of the opaque request tag carried to the result
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge
- in_func  in  4  function code (see Operation)
- in_a, in_b  in  32  operands
- in_tag  in  TAG_W  request tag
- alu_a, alu_b  out  32  registered operands to the ALU
- alu_op  out  4  registered ALU operation code
- alu_result  in  32  combinational ALU result for the current alu_a/alu_b/alu_op
- out_valid  out  1  result available (FIFO head)
- out_ready  in  1  consumer takes head when out_valid && out_ready at a rising edge
- out_result  out  32  result; 0 for illegal requests
- out_zero  out  1  out_result == 0
- out_err  out  1  request had an illegal in_func
- out_tag  out  TAG_W  tag of the request

## Operation
- Function-code decode to ALU op:
  - 0 ADD → 0000
  - 1 SUB a−b → 0110
  - 2 RSUB b−a → 0101
  - 3 AND → 1000
  - 4 OR → 1001
  - 5 XOR → 1100
  - 6 PASSB → 1101
  - 7 ANDN a&~b → 1010
  - 8 ORN ~b|a → 1011
  - 9 XNOR a^~b → 1110
  - 10 NOTB → 1111
  - 11–15: illegal.
- Illegal requests: alu_op is driven 0000, never an undefined code. The captured result is forced to 0, with err=1 and zero=1.
- Stage 1 (issue register) holds s1_valid, alu_a, alu_b, alu_op, tag, illegal flag. It loads on every accepted request and clears s1_valid otherwise.
- Stage 2 (result FIFO): when s1_valid=1, {alu_result or 0, zero, err, tag} is pushed on the next edge.
- in_ready = (fifo_count + s1_valid) < DEPTH.
  - Depends only on registered state; there is no combinational path from out_ready or in_valid.
  - This guarantees that a push never finds the FIFO full.
- Simultaneous push and pop: count is unchanged, and both pointers advance modulo DEPTH.
- Pop on empty is impossible (out_valid=0).
- Arithmetic is 32-bit modulo 2^32. No carry or overflow is reported.

## Timing
- Request accepted at edge k. alu_a/alu_b/alu_op show it during cycle k→k+1, and the result is pushed at edge k+1. out_valid is high from k+1 if the FIFO was empty.
- Latency: 2 edges from acceptance to consumption at the earliest.
- Throughput: 1 request/cycle sustained while out_ready=1.
- out_* are stable while out_valid=1 and out_ready=0.
- Reset values:
  - in_ready 1
  - out_valid 0; out_result, out_tag 0; out_err 0
  - out_zero 1 (empty head reads as 0)
  - alu_a, alu_b 0; alu_op 0000
  - s1_valid 0; FIFO pointers and count 0
- Reset mid-operation: in-flight and buffered results are discarded with no output pulse. Accepting resumes on the first edge after rst_n deasserts.

## Structure
- Package alu_pkg holds:
  - function-code localparams (FN_ADD…FN_NOTB)
  - ALU op-code localparams (OP_ADD=4'b0000 … OP_NOTB=4'b1111)
  - the decode function returning {illegal, op}
- The ALU itself is instantiated outside this block.
- One sub-module: alu_result_fifo, parameterised on DEPTH and payload width. It provides push, pop, count, head data, and an asynchronous active-low reset.

## Test plan
- ADD a=0xFFFFFFFF, b=1, tag=3, out_ready=1 → alu_op=0000 one cycle after accept; out_result=0, out_zero=1, out_err=0, out_tag=3 two cycles after.
- Back-to-back 8 requests, funcs 0–7, a=0x0F0F0F0F, b=0x00FF00FF, out_ready=1 → in_ready stays 1; results in order, 1/cycle. Expected: ADD 0x100E100E; SUB 0x0E100E10; RSUB 0xF1EFF1F0; ANDN 0x0F000F00.
- out_ready=0 with DEPTH=4 → exactly 4 requests accepted, then in_ready=0. Raising out_ready for one cycle allows exactly one more accept.
- in_func=12, a=5, b=7 → alu_op=0000; out_result=0, out_err=1, out_zero=1.
- NOTB b=0 and XNOR a=b=0x12345678 → results 0xFFFFFFFF and 0xFFFFFFFF, out_zero=0.
- Assert rst_n low with 3 results buffered and one in stage 1 → out_valid=0 immediately. After release, a fresh ADD 2+2 returns 4 as the first result.
